apex_seq_ctrl: RTL

APEX_SEQ_CTRL -- requirements
Module: apex_seq_ctrl

---
 rtl/apex_seq_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/apex_seq_ctrl.sv
// Enabled up-counter with terminal-count pulse, sticky irq/ovf flags,
// and a registered channel select/decode path.
module apex_seq_ctrl #(
  parameter  int CNT_W = 7,
  parameter  int NCH   = 6,
  localparam int SEL_W = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
  input  logic             pi_clk,
  input  logic             pi_rst_n,
  input  logic             en,
  input  logic             cnt_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] match_val,
  input  logic             sat_mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [NCH-1:0]   ch_data,
  input  logic             ack,
  output logic [CNT_W-1:0] cnt,
  output logic             tc,
  output logic             irq,
  output logic             ovf,
  output logic             ch_bit,
  output logic [NCH-1:0]   ch_onehot
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             ch_bit_q, ch_bit_d;
  logic [NCH-1:0]   ch_oh_q, ch_oh_d;
  logic             inc_done;

  always_comb begin
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    inc_done = 1'b0;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
        ovf_d = 1'b0;
      end else if (cnt_en) begin
        if (cnt_q == '1) begin
          ovf_d = 1'b1;
          // saturating hold is not a performed increment
          if (!sat_mode) begin
            cnt_d    = '0;
            inc_done = 1'b1;
          end
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          inc_done = 1'b1;
        end
      end
    end
    tc_d  = inc_done && (cnt_d == match_val);
    irq_d = tc_d ? 1'b1 : (ack ? 1'b0 : irq_q);
  end

  // out-of-range sel matches no channel, giving zero outputs
  always_comb begin
    ch_bit_d = 1'b0;
    ch_oh_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (en && sel == SEL_W'(i)) begin
        ch_bit_d   = ch_data[i];
        ch_oh_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      cnt_q    <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ch_bit_q <= 1'b0;
      ch_oh_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      ch_bit_q <= ch_bit_d;
      ch_oh_q  <= ch_oh_d;
    end
  end

  assign cnt       = cnt_q;
  assign tc        = tc_q;
  assign irq       = irq_q;
  assign ovf       = ovf_q;
  assign ch_bit    = ch_bit_q;
  assign ch_onehot = ch_oh_q;

endmodule
